// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the two-requester ALU arbiter.
package alu_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_e;

  typedef logic grant_t;

  localparam int TIMEOUT_CYCLES_DEF = 64;

endpackage

// File: rtl/alu_arb_watchdog.sv
// WAIT-state cycle counter; flags expiry in the TIMEOUT_CYCLES-th WAIT cycle.
module alu_arb_watchdog
  import alu_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic count_en_i,
  output logic expired_o
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Counter reads 0 in the first WAIT cycle, so expiry lands on count TIMEOUT_CYCLES-1.
  assign expired_o = count_en_i && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (count_en_i && !expired_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one multi-cycle ALU between two requesters.
// Optional WAIT timeout is enabled by defining ALU_ARB_TIMEOUT_EN.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          req_valid,
  output logic [1:0]          req_ready,
  input  logic [2*DATA_W-1:0] req_a,
  input  logic [2*DATA_W-1:0] req_b,
  output logic [1:0]          rsp_valid,
  input  logic [1:0]          rsp_ready,
  output logic [DATA_W-1:0]   rsp_data,
  output logic                rsp_err,
  output logic [DATA_W-1:0]   alu_a,
  output logic [DATA_W-1:0]   alu_b,
  output logic                alu_in_valid,
  input  logic [DATA_W-1:0]   alu_out,
  input  logic                alu_out_valid,
  output arb_state_e          dbg_state
);

  // Handshakes: a transfer happens in any cycle where valid and ready of the
  // same bit are both 1; valid never waits on ready, ready may depend on valid.

  arb_state_e          state_q;
  grant_t              grant_q;
  grant_t              last_q;
  grant_t              pick;
  logic [DATA_W-1:0]   a_q;
  logic [DATA_W-1:0]   b_q;
  logic [DATA_W-1:0]   data_q;
  logic [1:0]          rsp_valid_q;
  logic                alu_in_valid_q;

  // Tie goes to whoever was not served last; a lone requester always wins.
  always_comb begin
    pick      = req_valid[1];
    req_ready = 2'b00;
    if (req_valid == 2'b11) begin
      pick = ~last_q;
    end
    if (rst_n && (state_q == ST_IDLE) && (req_valid != 2'b00)) begin
      req_ready = pick ? 2'b10 : 2'b01;
    end
  end

`ifdef ALU_ARB_TIMEOUT_EN
  logic wd_expired;
  logic err_q;

  alu_arb_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_i   (state_q == ST_ISSUE),
    .count_en_i(state_q == ST_WAIT),
    .expired_o (wd_expired)
  );

  assign rsp_err = err_q;
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = 32'(TIMEOUT_CYCLES);
  assign rsp_err        = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      grant_q        <= 1'b0;
      last_q         <= 1'b1;
      a_q            <= '0;
      b_q            <= '0;
      data_q         <= '0;
      rsp_valid_q    <= 2'b00;
      alu_in_valid_q <= 1'b0;
`ifdef ALU_ARB_TIMEOUT_EN
      err_q          <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid != 2'b00) begin
            grant_q        <= pick;
            a_q            <= pick ? req_a[2*DATA_W-1:DATA_W] : req_a[DATA_W-1:0];
            b_q            <= pick ? req_b[2*DATA_W-1:DATA_W] : req_b[DATA_W-1:0];
            alu_in_valid_q <= 1'b1;
            state_q        <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          alu_in_valid_q <= 1'b0;
          state_q        <= ST_WAIT;
        end
        ST_WAIT: begin
          // A real result beats a timeout expiring in the same cycle.
          if (alu_out_valid) begin
            data_q      <= alu_out;
            rsp_valid_q <= grant_q ? 2'b10 : 2'b01;
            state_q     <= ST_RESP;
`ifdef ALU_ARB_TIMEOUT_EN
            err_q       <= 1'b0;
          end else if (wd_expired) begin
            data_q      <= '0;
            err_q       <= 1'b1;
            rsp_valid_q <= grant_q ? 2'b10 : 2'b01;
            state_q     <= ST_RESP;
`endif
          end
        end
        ST_RESP: begin
          if (rsp_ready[grant_q]) begin
            last_q      <= grant_q;
            a_q         <= '0;
            b_q         <= '0;
            data_q      <= '0;
            rsp_valid_q <= 2'b00;
            state_q     <= ST_IDLE;
`ifdef ALU_ARB_TIMEOUT_EN
            err_q       <= 1'b0;
`endif
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign rsp_valid    = rsp_valid_q;
  assign rsp_data     = data_q;
  assign alu_a        = a_q;
  assign alu_b        = b_q;
  assign alu_in_valid = alu_in_valid_q;
  assign dbg_state    = state_q;

endmodule
